simmem_wreq_generator: RTL and testbench

- Requester-side transmitter for the simulated-memory write path: one burst command in, one write address request plus N write data beats out.
- Drives the same waddr/wdata valid-ready channels that the delay calculator snoops.
- Programmable data-vs-address ordering so benches can exercise three cases: data leading the address, data concurrent with it, and data strictly after it.
- Used as a stimulus source in block and top-level simulation. One burst in flight at a time.

---
 rtl/simmem_pkg.sv | 31 +++
 rtl/simmem_wreq_generator.sv | 134 +++++++++++++
 tb/tb_simmem_wreq_generator.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/simmem_pkg.sv
// Shared types and sizing for the simulated-memory write path.
// Also holds the state encoding of the write-request generator.
package simmem_pkg;

  localparam int unsigned IdWidth     = 4;
  localparam int unsigned AxAddrWidth = 16;
  localparam int unsigned AxLenWidth  = 4;
  localparam int unsigned AxSizeWidth = 3;
  localparam int unsigned AxBurstWidth = 2;

  // burst_length is a beat count, so the longest burst is all-ones in AxLenWidth bits.
  localparam int unsigned MaxWBurstLen      = (1 << AxLenWidth) - 1;
  localparam int unsigned MaxWBurstLenWidth = AxLenWidth;

  typedef struct packed {
    logic [IdWidth-1:0]      id;
    logic [AxAddrWidth-1:0]  addr;
    logic [AxLenWidth-1:0]   burst_length;
    logic [AxSizeWidth-1:0]  burst_size;
    logic [AxBurstWidth-1:0] burst_type;
  } waddr_t;

  typedef enum logic [2:0] {
    IDLE,
    LEAD,
    ADDR,
    DATA,
    DONE
  } wreq_gen_state_e;

endpackage

// File: rtl/simmem_wreq_generator.sv
// Requester-side write burst source: one command in, one address request plus
// burst_length data beats out, with programmable data-vs-address ordering.
module simmem_wreq_generator
  import simmem_pkg::*;
#(
  parameter int unsigned CntWidth = 32
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         cmd_valid_i,
  output logic                         cmd_ready_o,
  input  waddr_t                       cmd_waddr_i,
  input  logic [MaxWBurstLenWidth:0]   cmd_lead_beats_i,
  input  logic                         cmd_addr_first_i,
  output waddr_t                       waddr_o,
  output logic                         waddr_valid_o,
  input  logic                         waddr_ready_i,
  output logic                         wdata_valid_o,
  input  logic                         wdata_ready_i,
  output logic [MaxWBurstLenWidth-1:0] wdata_beat_o,
  output logic                         wdata_last_o,
  output logic                         done_o,
  output logic [CntWidth-1:0]          beats_sent_o,
  output logic [CntWidth-1:0]          bursts_sent_o
);

  wreq_gen_state_e              state_q, state_d;
  waddr_t                       waddr_q, waddr_d;
  logic [AxLenWidth-1:0]        beats_left_q, beats_left_d;
  logic [AxLenWidth-1:0]        lead_left_q, lead_left_d;
  logic [MaxWBurstLenWidth-1:0] beat_idx_q, beat_idx_d;
  logic                         addr_first_q, addr_first_d;
  logic [CntWidth-1:0]          beats_sent_q, beats_sent_d;
  logic [CntWidth-1:0]          bursts_sent_q, bursts_sent_d;

  logic [AxLenWidth-1:0] lead_sat;
  logic                  waddr_hs;
  logic                  wdata_hs;

  // Lead requests beyond the burst length simply mean "all data before the address".
  assign lead_sat = (cmd_lead_beats_i > {1'b0, cmd_waddr_i.burst_length})
                  ? cmd_waddr_i.burst_length
                  : cmd_lead_beats_i[AxLenWidth-1:0];

  // Valids come from registered state only, so they never follow ready combinationally.
  assign cmd_ready_o   = (state_q == IDLE);
  assign done_o        = (state_q == DONE);
  assign waddr_valid_o = (state_q == ADDR);
  assign wdata_valid_o = (state_q == LEAD) || (state_q == DATA) ||
                         ((state_q == ADDR) && (beats_left_q != '0) && !addr_first_q);

  assign waddr_hs = waddr_valid_o && waddr_ready_i;
  assign wdata_hs = wdata_valid_o && wdata_ready_i;

  assign waddr_o       = waddr_q;
  assign wdata_beat_o  = beat_idx_q;
  assign wdata_last_o  = wdata_valid_o && (beats_left_q == AxLenWidth'(1));
  assign beats_sent_o  = beats_sent_q;
  assign bursts_sent_o = bursts_sent_q;

  always_comb begin
    // NOTE: every variable gets a default before the case so no path infers a latch.
    state_d       = state_q;
    waddr_d       = waddr_q;
    beats_left_d  = beats_left_q;
    lead_left_d   = lead_left_q;
    beat_idx_d    = beat_idx_q;
    addr_first_d  = addr_first_q;
    beats_sent_d  = beats_sent_q;
    bursts_sent_d = bursts_sent_q;

    if (wdata_hs) begin
      beats_left_d = beats_left_q - AxLenWidth'(1);
      beat_idx_d   = beat_idx_q + MaxWBurstLenWidth'(1);
      beats_sent_d = beats_sent_q + CntWidth'(1);
    end

    unique case (state_q)
      IDLE: begin
        if (cmd_valid_i) begin
          waddr_d      = cmd_waddr_i;
          beats_left_d = cmd_waddr_i.burst_length;
          lead_left_d  = lead_sat;
          beat_idx_d   = '0;
          addr_first_d = cmd_addr_first_i;
          state_d      = (cmd_addr_first_i || (lead_sat == '0)) ? ADDR : LEAD;
        end
      end
      LEAD: begin
        if (wdata_hs) begin
          lead_left_d = lead_left_q - AxLenWidth'(1);
          if (lead_left_q == AxLenWidth'(1)) state_d = ADDR;
        end
      end
      ADDR: begin
        // beats_left_d already reflects a data beat accepted in this same cycle.
        if (waddr_hs) state_d = (beats_left_d == '0) ? DONE : DATA;
      end
      DATA: begin
        if (wdata_hs && (beats_left_q == AxLenWidth'(1))) state_d = DONE;
      end
      DONE: begin
        bursts_sent_d = bursts_sent_q + CntWidth'(1);
        state_d       = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
  // NOTE: all registers are small, so all of them take the async reset; nothing is left X.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= IDLE;
      waddr_q       <= '0;
      beats_left_q  <= '0;
      lead_left_q   <= '0;
      beat_idx_q    <= '0;
      addr_first_q  <= 1'b0;
      beats_sent_q  <= '0;
      bursts_sent_q <= '0;
    end else begin
      state_q       <= state_d;
      waddr_q       <= waddr_d;
      beats_left_q  <= beats_left_d;
      lead_left_q   <= lead_left_d;
      beat_idx_q    <= beat_idx_d;
      addr_first_q  <= addr_first_d;
      beats_sent_q  <= beats_sent_d;
      bursts_sent_q <= bursts_sent_d;
    end
  end

endmodule

// File: tb/tb_simmem_wreq_generator.sv
// Self-checking bench for simmem_wreq_generator: directed and random bursts
// compared every cycle against a transaction-level model of the burst rules.
module tb_simmem_wreq_generator;
  import simmem_pkg::*;

  localparam int unsigned CntWidth = 32;

  logic                         clk_i = 1'b0;
  logic                         rst_ni;
  logic                         cmd_valid_i;
  logic                         cmd_ready_o;
  waddr_t                       cmd_waddr_i;
  logic [MaxWBurstLenWidth:0]   cmd_lead_beats_i;
  logic                         cmd_addr_first_i;
  waddr_t                       waddr_o;
  logic                         waddr_valid_o;
  logic                         waddr_ready_i;
  logic                         wdata_valid_o;
  logic                         wdata_ready_i;
  logic [MaxWBurstLenWidth-1:0] wdata_beat_o;
  logic                         wdata_last_o;
  logic                         done_o;
  logic [CntWidth-1:0]          beats_sent_o;
  logic [CntWidth-1:0]          bursts_sent_o;

  always #5 clk_i = ~clk_i;

  simmem_wreq_generator #(.CntWidth(CntWidth)) dut (
    .clk_i            (clk_i),
    .rst_ni           (rst_ni),
    .cmd_valid_i      (cmd_valid_i),
    .cmd_ready_o      (cmd_ready_o),
    .cmd_waddr_i      (cmd_waddr_i),
    .cmd_lead_beats_i (cmd_lead_beats_i),
    .cmd_addr_first_i (cmd_addr_first_i),
    .waddr_o          (waddr_o),
    .waddr_valid_o    (waddr_valid_o),
    .waddr_ready_i    (waddr_ready_i),
    .wdata_valid_o    (wdata_valid_o),
    .wdata_ready_i    (wdata_ready_i),
    .wdata_beat_o     (wdata_beat_o),
    .wdata_last_o     (wdata_last_o),
    .done_o           (done_o),
    .beats_sent_o     (beats_sent_o),
    .bursts_sent_o    (bursts_sent_o)
  );

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  // Reference model: a burst is a count of accepted beats plus an "address sent" flag.
  typedef enum int {P_IDLE, P_ACT, P_DONE} phase_e;
  phase_e      m_phase;
  waddr_t      m_cmd;
  int unsigned m_len, m_lead_eff, m_acc, m_beats, m_bursts, act_cyc;
  bit          m_af, m_addr_done;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_phase     = P_IDLE;
    m_cmd       = '0;
    m_len       = 0;
    m_lead_eff  = 0;
    m_acc       = 0;
    m_beats     = 0;
    m_bursts    = 0;
    act_cyc     = 0;
    m_af        = 1'b0;
    m_addr_done = 1'b0;
  endtask

  // One cycle: drive at negedge, check outputs, then advance the model at posedge.
  task automatic tick(input logic ra, input logic rd, input logic cv);
    logic e_av, e_dv, ha, hd, hc;
    waddr_ready_i = ra;
    wdata_ready_i = rd;
    cmd_valid_i   = cv;
    #1;
    // Address goes out once the lead beats are in; data flows unless it must wait for the address.
    e_av = (m_phase == P_ACT) && !m_addr_done && (m_acc >= m_lead_eff);
    e_dv = (m_phase == P_ACT) && (m_acc < m_len) && (!m_af || m_addr_done);
    chk("cmd_ready",   64'(cmd_ready_o),   64'(m_phase == P_IDLE));
    chk("done",        64'(done_o),        64'(m_phase == P_DONE));
    chk("waddr_valid", 64'(waddr_valid_o), 64'(e_av));
    chk("wdata_valid", 64'(wdata_valid_o), 64'(e_dv));
    chk("beats_sent",  64'(beats_sent_o),  64'(m_beats));
    chk("bursts_sent", 64'(bursts_sent_o), 64'(m_bursts));
    if (e_dv) begin
      chk("wdata_beat", 64'(wdata_beat_o), 64'(m_acc));
      chk("wdata_last", 64'(wdata_last_o), 64'(m_acc + 1 == m_len));
    end
    if (e_av) chk("waddr_payload", 64'(waddr_o), 64'(m_cmd));
    ha = e_av && ra;
    hd = e_dv && rd;
    hc = (m_phase == P_IDLE) && cv;
    @(posedge clk_i);
    if (m_phase == P_DONE) begin
      m_phase = P_IDLE;
      m_bursts++;
    end else if (hc) begin
      m_cmd       = cmd_waddr_i;
      m_len       = int'(cmd_waddr_i.burst_length);
      m_af        = cmd_addr_first_i;
      m_lead_eff  = m_af ? 0 : ((int'(cmd_lead_beats_i) < m_len) ? int'(cmd_lead_beats_i) : m_len);
      m_acc       = 0;
      m_addr_done = 1'b0;
      act_cyc     = 0;
      m_phase     = P_ACT;
    end else if (m_phase == P_ACT) begin
      if (hd) begin
        m_acc++;
        m_beats++;
      end
      if (ha) m_addr_done = 1'b1;
      act_cyc++;
      if (m_addr_done && (m_acc == m_len)) m_phase = P_DONE;
    end
    @(negedge clk_i);
  endtask

  task automatic set_cmd(input int unsigned len, input int unsigned lead, input bit af);
    waddr_t c;
    c.id             = IdWidth'($urandom);
    c.addr           = AxAddrWidth'($urandom);
    c.burst_length   = AxLenWidth'(len);
    c.burst_size     = AxSizeWidth'($urandom);
    c.burst_type     = AxBurstWidth'($urandom);
    cmd_waddr_i      = c;
    cmd_lead_beats_i = (MaxWBurstLenWidth + 1)'(lead);
    cmd_addr_first_i = af;
  endtask

  // mode 0: readies high; 1: waddr_ready low for 5 active cycles, wdata_ready 1010...; 2: random.
  task automatic run_burst(input int unsigned len, input int unsigned lead, input bit af,
                           input int unsigned mode);
    bit          started  = 1'b0;
    bit          finished = 1'b0;
    int unsigned gap;
    logic        ra, rd, cv;
    set_cmd(len, lead, af);
    gap = (mode == 2) ? $urandom_range(0, 2) : 0;
    for (int i = 0; i < 400 && !finished; i++) begin
      cv = (m_phase == P_IDLE) && !started && (i >= int'(gap));
      unique case (mode)
        0:       begin ra = 1'b1;                rd = 1'b1;                  end
        1:       begin ra = (act_cyc >= 5);      rd = ((act_cyc % 2) == 0);  end
        default: begin ra = 1'($urandom);        rd = 1'($urandom);          end
      endcase
      tick(ra, rd, cv);
      if (cv) started = 1'b1;
      else if (started && (m_phase == P_IDLE)) finished = 1'b1;
    end
    cmd_valid_i = 1'b0;
    chk("burst_finished", 64'(finished), 64'(1));
  endtask

  initial begin
    rst_ni           = 1'b0;
    cmd_valid_i      = 1'b0;
    cmd_waddr_i      = '0;
    cmd_lead_beats_i = '0;
    cmd_addr_first_i = 1'b0;
    waddr_ready_i    = 1'b0;
    wdata_ready_i    = 1'b0;
    model_reset();
    repeat (2) @(negedge clk_i);
    chk("rst_cmd_ready",   64'(cmd_ready_o),   64'(1));
    chk("rst_waddr_valid", 64'(waddr_valid_o), 64'(0));
    chk("rst_wdata_valid", 64'(wdata_valid_o), 64'(0));
    chk("rst_done",        64'(done_o),        64'(0));
    chk("rst_waddr",       64'(waddr_o),       64'(0));
    chk("rst_beat",        64'(wdata_beat_o),  64'(0));
    chk("rst_beats_sent",  64'(beats_sent_o),  64'(0));
    rst_ni = 1'b1;
    tick(1'b0, 1'b0, 1'b0);

    run_burst(4, 0, 1'b1, 0);   // address first
    run_burst(1, 0, 1'b0, 0);   // concurrent address and single last beat
    run_burst(3, 7, 1'b0, 0);   // lead saturates: all data before address
    run_burst(4, 2, 1'b0, 1);   // backpressure on both channels
    run_burst(0, 0, 1'b0, 0);   // zero-length burst: address only
    run_burst(0, 5, 1'b1, 2);
    run_burst(15, 16, 1'b0, 2);

    // Reset in the middle of DATA after two of eight beats.
    set_cmd(8, 0, 1'b1);
    for (int i = 0; i < 50 && !((m_phase == P_ACT) && (m_acc == 2)); i++)
      tick(1'b1, 1'b1, (m_phase == P_IDLE) && (i == 0));
    cmd_valid_i = 1'b0;
    chk("mid_burst_reached", 64'(m_acc), 64'(2));
    rst_ni = 1'b0;
    #1;
    chk("arst_waddr_valid", 64'(waddr_valid_o), 64'(0));
    chk("arst_wdata_valid", 64'(wdata_valid_o), 64'(0));
    chk("arst_cmd_ready",   64'(cmd_ready_o),   64'(1));
    chk("arst_beats_sent",  64'(beats_sent_o),  64'(0));
    chk("arst_bursts_sent", 64'(bursts_sent_o), 64'(0));
    model_reset();
    @(negedge clk_i);
    rst_ni = 1'b1;
    tick(1'b0, 1'b0, 1'b0);
    run_burst(2, 0, 1'b0, 0);

    for (int n = 0; n < 40; n++)
      run_burst($urandom_range(0, MaxWBurstLen), $urandom_range(0, 20),
                1'($urandom_range(0, 1)), $urandom_range(0, 2));
    tick(1'b1, 1'b1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
